compress42_mul_pipe: RTL

Parametrised, 3-stage pipelined WIDTH x WIDTH multiplier for the M-extension execute path. It reduces partial products with a tree of chained 4:2 compressor slices down to two rows, then resolves them with a single carry-propagate add. Supports MUL/MULH/MULHSU/MULHU, valid/ready handshakes on both sides, a pass-through tag and a pipeline flush. Throughput is one operation per cycle.

---
 rtl/compress42_mul_pipe.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/compress42_mul_pipe.sv
// rtl/compress42_mul_pipe.sv - 3-stage pipelined WIDTH x WIDTH multiplier using a 4:2 compressor tree
// R1 holds partial products, R2 the two compressed rows, R3 the selected product half.
module compress42_mul_pipe #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [TAG_W-1:0] tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);
    localparam int PW = 2 * WIDTH + 2;
    localparam int NR = WIDTH + 1;

    // Bit-sliced 4:2 compressor; the inter-slice carry ripples LSB->MSB and drops off the top.
    function automatic logic [2*PW-1:0] c42(input logic [PW-1:0] x0, x1, x2, x3);
        logic [PW-1:0] s, c;
        logic          cin, cout, s1;
        s   = '0;
        c   = '0;
        cin = 1'b0;
        for (int j = 0; j < PW; j++) begin
            s1   = x0[j] ^ x1[j] ^ x2[j];
            cout = (x0[j] & x1[j]) | (x0[j] & x2[j]) | (x1[j] & x2[j]);
            s[j] = s1 ^ x3[j] ^ cin;
            if (j + 1 < PW) c[j+1] = (s1 & x3[j]) | (s1 & cin) | (x3[j] & cin);
            cin = cout;
        end
        return {c, s};
    endfunction

    function automatic logic [2*PW-1:0] c32(input logic [PW-1:0] x0, x1, x2);
        logic [PW-1:0] s, c;
        s = x0 ^ x1 ^ x2;
        c = ((x0 & x1) | (x0 & x2) | (x1 & x2)) << 1;
        return {c, s};
    endfunction

    logic             v1_q, v2_q, v3_q, v1_d, v2_d, v3_d;
    logic             adv1, adv2, adv3;
    logic [PW-1:0]    pp_q [0:NR-1];
    logic [PW-1:0]    pp_d [0:NR-1];
    logic [1:0]       op1_q, op2_q;
    logic [TAG_W-1:0] tag1_q, tag2_q;
    logic [PW-1:0]    sum_q, carry_q, sum_d, carry_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;
    logic             a_sgn, b_sgn;
    logic [WIDTH:0]   b_ext;
    logic [PW-1:0]    a_sx, full;
    logic             unused_hi;

    assign adv3     = !v3_q || out_ready;
    assign adv2     = !v2_q || adv3;
    assign adv1     = !v1_q || adv2;
    assign in_ready = !flush && adv1;
    assign busy     = v1_q | v2_q | v3_q;

    assign out_valid = v3_q;
    assign result    = result_q;
    assign out_tag   = out_tag_q;

    assign a_sgn = (op == 2'b01) || (op == 2'b10);
    assign b_sgn = (op == 2'b01);
    assign a_sx  = {{(WIDTH + 2){a_sgn & a[WIDTH-1]}}, a};
    assign b_ext = {b_sgn & b[WIDTH-1], b};

    // The top multiplier bit carries negative weight, so its row is subtracted.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) pp_d[i] = b_ext[i] ? (a_sx << i) : '0;
        pp_d[WIDTH] = b_ext[WIDTH] ? (~(a_sx << WIDTH) + PW'(1)) : '0;
    end

    always_comb begin
        logic [PW-1:0] t [0:NR-1];
        int cnt, ng, r, n;
        for (int i = 0; i < NR; i++) t[i] = pp_q[i];
        cnt = NR;
        ng  = 0;
        r   = 0;
        n   = 0;
        for (int lv = 0; lv < NR; lv++) begin
            if (cnt > 2) begin
                ng = cnt / 4;
                for (int g = 0; g < NR / 4; g++) begin
                    if (g < ng) {t[2*g+1], t[2*g]} = c42(t[4*g], t[4*g+1], t[4*g+2], t[4*g+3]);
                end
                r = cnt - 4 * ng;
                n = 2 * ng;
                if (r == 3) begin
                    {t[n+1], t[n]} = c32(t[4*ng], t[4*ng+1], t[4*ng+2]);
                    n = n + 2;
                end else if (r == 2) begin
                    t[n]   = t[4*ng];
                    t[n+1] = t[4*ng+1];
                    n = n + 2;
                end else if (r == 1) begin
                    t[n] = t[4*ng];
                    n = n + 1;
                end
                cnt = n;
            end
        end
        sum_d   = t[0];
        carry_d = t[1];
    end

    assign full      = sum_q + carry_q;
    assign unused_hi = ^full[PW-1:2*WIDTH];

    always_comb begin
        v1_d      = flush ? 1'b0 : (adv1 ? (in_valid && in_ready) : v1_q);
        v2_d      = flush ? 1'b0 : (adv2 ? v1_q : v2_q);
        v3_d      = flush ? 1'b0 : (adv3 ? v2_q : v3_q);
        result_d  = result_q;
        out_tag_d = out_tag_q;
        if (adv3 && v2_q) begin
            result_d  = (op2_q == 2'b00) ? full[WIDTH-1:0] : full[2*WIDTH-1:WIDTH];
            out_tag_d = tag2_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            v3_q      <= 1'b0;
            result_q  <= '0;
            out_tag_q <= '0;
        end else begin
            v1_q      <= v1_d;
            v2_q      <= v2_d;
            v3_q      <= v3_d;
            result_q  <= result_d;
            out_tag_q <= out_tag_d;
        end
    end

    always_ff @(posedge clk) begin
        if (adv1) begin
            pp_q   <= pp_d;
            op1_q  <= op;
            tag1_q <= tag;
        end
        if (adv2) begin
            sum_q   <= sum_d;
            carry_q <= carry_d;
            op2_q   <= op1_q;
            tag2_q  <= tag1_q;
        end
    end
endmodule
